// File: rtl/des_frame_ctrl.sv
// rtl/des_frame_ctrl.sv - SPI frame control stage: key load, DES launch, result return
// Frames end on synchronized cs_n rising; results reach output_text only while cs_s is high.
module des_frame_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic [63:0] input_text,
  output logic [63:0] output_text,
  input  logic        decrypt,
  input  logic        rekey,
  output logic        des_start,
  output logic        des_decrypt,
  output logic [63:0] des_key,
  output logic [63:0] des_din,
  input  logic        des_done,
  input  logic [63:0] des_dout,
  output logic        key_valid,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   cs_s;
  logic                   cs_s_d;
  logic                   frame_end;
  logic [CW-1:0]          tmo_cnt;
  logic                   tmo_hit;
  logic [63:0]            res_buf;
  logic                   res_pend;
  logic                   load_key;
  logic                   launch;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign frame_end = cs_s & ~cs_s_d;
  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT));
  // A rekey pulse coinciding with frame_end makes that very frame the key.
  assign load_key  = (state == IDLE) && frame_end && (!key_valid || rekey);
  assign launch    = (state == IDLE) && frame_end && key_valid && !rekey;

  // Chain resets high so that reset release never looks like a frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync <= '1;
      cs_s_d  <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      cs_s_d  <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = START;
      START:   state_nx = BUSY;
      BUSY:    if (des_done || tmo_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    des_start = (state == START);
    busy      = (state == START) || (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt     <= '0;
      des_key     <= '0;
      key_valid   <= 1'b0;
      des_din     <= '0;
      des_decrypt <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      res_buf     <= '0;
      res_pend    <= 1'b0;
      output_text <= '0;
    end else begin
      if (state == START)                tmo_cnt <= '0;
      else if (state == BUSY && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);

      if (load_key) begin
        des_key   <= input_text;
        key_valid <= 1'b1;
      end else if (rekey) begin
        key_valid <= 1'b0;
      end

      if (launch) begin
        des_din     <= input_text;
        des_decrypt <= decrypt;
      end

      if (frame_end && state != IDLE) err_overrun <= 1'b1;

      // MISO word is only touched between frames; a fresh result below re-arms res_pend.
      if (res_pend && cs_s) begin
        output_text <= res_buf;
        res_pend    <= 1'b0;
      end

      if (state == BUSY) begin
        if (des_done) begin
          res_buf  <= des_dout;
          res_pend <= 1'b1;
        end else if (tmo_hit) begin
          err_timeout <= 1'b1;
          res_buf     <= '1;
          res_pend    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_frame_ctrl.sv
// tb/tb_des_frame_ctrl.sv - self-checking bench for des_frame_ctrl with XOR DES stub
// Expected words come from frame-level rules: result = block ^ key, all-ones on timeout.
module tb_des_frame_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;
  localparam int LAT         = SYNC_STAGES + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs_n = 1'b1;
  logic [63:0] input_text = '0;
  logic [63:0] output_text;
  logic        decrypt = 1'b0;
  logic        rekey = 1'b0;
  logic        des_start;
  logic        des_decrypt;
  logic [63:0] des_key;
  logic [63:0] des_din;
  logic        des_done;
  logic [63:0] des_dout;
  logic        key_valid;
  logic        busy;
  logic        err_overrun;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  logic stall = 1'b0;
  int stub_cnt = 0;
  logic [63:0] stub_val = '0;

  always #5 clk = ~clk;

  des_frame_ctrl #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .input_text(input_text),
    .output_text(output_text), .decrypt(decrypt), .rekey(rekey),
    .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key),
    .des_din(des_din), .des_done(des_done), .des_dout(des_dout),
    .key_valid(key_valid), .busy(busy), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  // DES stand-in: result = din ^ key, one done pulse 16 clk after launch.
  initial begin
    des_done = 1'b0;
    des_dout = '0;
  end
  always @(posedge clk) begin
    des_done <= 1'b0;
    if (!rst) begin
      stub_cnt <= 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !stall) begin
          des_done <= 1'b1;
          des_dout <= stub_val;
        end
      end
      if (des_start) begin
        stub_cnt <= 16;
        stub_val <= des_din ^ des_key;
      end
    end
  end

  always @(posedge clk) if (des_start) starts <= starts + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One SPI frame: cs_n low, word presented, cs_n high; lat = cycles to des_start or -1.
  task automatic run_frame(input logic [63:0] d, input logic dec, output int lat);
    cs_n = 1'b0;
    repeat (4) tick();
    input_text = d;
    decrypt    = dec;
    cs_n       = 1'b1;
    lat        = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (des_start === 1'b1 && lat < 0) lat = i;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp_key;
    logic [63:0] d;
    logic [63:0] held;
    logic        dec;
    logic        changed;
    int          lat;
    int          s0;

    repeat (3) tick();
    check("rst_out", output_text, 64'd0);
    check("rst_key", des_key, 64'd0);
    check("rst_flags", {58'd0, key_valid, busy, des_start, des_decrypt, err_overrun, err_timeout}, 64'd0);
    rst = 1'b1;
    repeat (2) tick();

    exp_key = 64'h1334_5779_9BBC_DFF1;
    run_frame(exp_key, 1'b0, lat);
    check("key_no_start", 64'(starts), 64'd0);
    check("key_valid", {63'd0, key_valid}, 64'd1);
    check("key_val", des_key, exp_key);

    d = 64'h0123_4567_89AB_CDEF;
    run_frame(d, 1'b0, lat);
    check("lat_first", 64'(lat), 64'(LAT));
    check("din_first", des_din, d);
    check("dec_first", {63'd0, des_decrypt}, 64'd0);
    wait_idle("idle_first", 100);
    tick();
    check("out_first", output_text, d ^ exp_key);

    for (int k = 0; k < 4; k++) begin
      d   = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      run_frame(d, dec, lat);
      check("lat_rand", 64'(lat), 64'(LAT));
      check("din_rand", des_din, d);
      check("dec_rand", {63'd0, des_decrypt}, {63'd0, dec});
      wait_idle("idle_rand", 100);
      tick();
      check("out_rand", output_text, d ^ exp_key);
    end

    s0 = starts;
    d  = {$urandom, $urandom};
    run_frame(d, 1'b0, lat);
    run_frame(~d, 1'b1, lat);
    check("ovr_flag", {63'd0, err_overrun}, 64'd1);
    check("ovr_second_lat", 64'(lat), -64'sd1);
    wait_idle("idle_ovr", 100);
    tick();
    check("ovr_starts", 64'(starts - s0), 64'd1);
    check("ovr_out", output_text, d ^ exp_key);

    stall = 1'b1;
    d = {$urandom, $urandom};
    run_frame(d, 1'b0, lat);
    check("tmo_lat", 64'(lat), 64'(LAT));
    wait_idle("idle_tmo", TIMEOUT + 100);
    tick();
    check("tmo_flag", {63'd0, err_timeout}, 64'd1);
    check("tmo_out", output_text, 64'hFFFF_FFFF_FFFF_FFFF);
    stall = 1'b0;
    d = {$urandom, $urandom};
    run_frame(d, 1'b0, lat);
    check("after_tmo_lat", 64'(lat), 64'(LAT));
    wait_idle("idle_after_tmo", 100);
    tick();
    check("after_tmo_out", output_text, d ^ exp_key);

    held = output_text;
    d = {$urandom, $urandom};
    run_frame(d, 1'b0, lat);
    cs_n    = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (output_text !== held) changed = 1'b1;
    end
    check("defer_hold", {63'd0, changed}, 64'd0);
    check("defer_done", {63'd0, busy}, 64'd0);
    input_text = ~d;
    cs_n = 1'b1;
    repeat (4) tick();
    check("defer_out", output_text, d ^ exp_key);
    wait_idle("idle_defer", 100);
    tick();
    check("defer_next_out", output_text, ~d ^ exp_key);

    held  = output_text;
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    check("rekey_kv", {63'd0, key_valid}, 64'd0);
    check("rekey_out", output_text, held);
    s0 = starts;
    exp_key = 64'h0F0F_0F0F_0F0F_0F0F;
    run_frame(exp_key, 1'b0, lat);
    check("rekey_no_start", 64'(starts - s0), 64'd0);
    check("rekey_key", des_key, exp_key);
    check("rekey_valid", {63'd0, key_valid}, 64'd1);

    d = {$urandom, $urandom};
    run_frame(d, 1'b0, lat);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out", output_text, 64'd0);
    check("mid_rst_key", des_key, 64'd0);
    check("mid_rst_din", des_din, 64'd0);
    check("mid_rst_flags", {58'd0, key_valid, busy, des_start, des_decrypt, err_overrun, err_timeout}, 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (30) tick();
    check("post_rst_out", output_text, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
